serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract engine. One full-adder cell is shared across all
//   bit positions and sequenced LSB-first, one bit per clock.

---
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract engine.
// The requester drives the master side and the engine uses the slave side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, op_sub, a, b, cin, out_ready,
    input  ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  start, op_sub, a, b, cin, out_ready,
    output ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: a single full-adder cell is sequenced
// LSB-first over WIDTH clocks, with start/ready in and valid/ready out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic fa_s, fa_c, last_bit;

  // The one shared full-adder cell.
  assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    bus.ready     = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the shift registers are small flop banks, not RAM, so they take the
  // async reset; an aborted operation then never leaks a stale carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub ? 1'b1 : bus.cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // On the MSB step `carry` is the carry into the MSB, so overflow
          // is formed here without a separate capture register.
          if (last_bit) begin
            sum_q  <= {fa_s, res_sh[WIDTH-1:1]};
            cout_q <= fa_c;
            ovf_q  <= carry ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed and random
// operations compared against an integer-arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] last_sum;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic sub, input logic [WIDTH-1:0] av,
                                              input logic [WIDTH-1:0] bv, input logic ci);
    int full, sres;
    logic [WIDTH-1:0] nb;
    logic co, ov;
    nb = ~bv;
    if (sub) begin
      full = int'(av) + int'(nb) + 1;
      sres = int'($signed(av)) - int'($signed(bv));
    end else begin
      full = int'(av) + int'(bv) + int'(ci);
      sres = int'($signed(av)) + int'($signed(bv)) + int'(ci);
    end
    co = full[WIDTH];
    ov = (sres > 127) || (sres < -128);
    return {co, ov, full[WIDTH-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation with out_ready low until completion, then consume it.
  task automatic run_op(input logic sub, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input string tag);
    logic [WIDTH+1:0] exp;
    int edges;
    exp = model(sub, av, bv, ci);
    check({tag, ":ready_before"}, bus.ready, 1);
    bus.op_sub = sub; bus.a = av; bus.b = bv; bus.cin = ci;
    bus.start = 1'b1; bus.out_ready = 1'b0;
    tick();
    edges = 1;
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
    bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
    while (!bus.out_valid && edges < 40) begin
      check({tag, ":sum_hidden"}, bus.sum, last_sum);
      tick();
      edges++;
    end
    check({tag, ":latency"}, edges, WIDTH + 1);
    check({tag, ":sum"},  bus.sum,  exp[WIDTH-1:0]);
    check({tag, ":cout"}, bus.cout, exp[WIDTH+1]);
    check({tag, ":ovf"},  bus.ovf,  exp[WIDTH]);
    last_sum = exp[WIDTH-1:0];
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ":ready_after"}, bus.ready, 1);
    check({tag, ":valid_after"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] e;
    int done_cyc[3];
    int n_done, issued, cyc;
    logic prev_ready;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    bus.cin = 1'b0; bus.out_ready = 1'b0;
    last_sum = '0;
    tick(); tick();
    check("rst:ready", bus.ready, 1);
    check("rst:out_valid", bus.out_valid, 0);
    check("rst:sum", bus.sum, 0);
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, "add_5a_3c");

    // Abort mid-RUN; outputs must clear in the same cycle.
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("abort:in_run", bus.ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort:ready", bus.ready, 1);
    check("abort:out_valid", bus.out_valid, 0);
    check("abort:sum", bus.sum, 0);
    check("abort:cout", bus.cout, 0);
    check("abort:ovf", bus.ovf, 0);
    last_sum = '0;
    tick();
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    run_op(1'b1, 8'h10, 8'h20, 1'b1, "sub_10_20");
    run_op(1'b1, 8'h80, 8'h01, 1'b0, "sub_80_01");
    for (int i = 0; i < 4; i++)
      run_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");

    // Backpressure: hold the result while start keeps pulsing.
    e = model(1'b0, 8'h33, 8'h44, 1'b1);
    bus.op_sub = 1'b0; bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12 && !bus.out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'(i % 2 == 0);
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      tick();
      check("bp:out_valid", bus.out_valid, 1);
      check("bp:ready", bus.ready, 0);
      check("bp:sum", bus.sum, e[WIDTH-1:0]);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp:ready_next", bus.ready, 1);
    check("bp:valid_drop", bus.out_valid, 0);
    check("bp:sum_kept", bus.sum, e[WIDTH-1:0]);
    last_sum = e[WIDTH-1:0];

    // Back-to-back: start held, out_ready high, three random ops.
    bus.op_sub = 1'($urandom); bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
    exp_q.push_back(model(bus.op_sub, bus.a, bus.b, bus.cin));
    issued = 1; n_done = 0; cyc = 0;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    prev_ready = bus.ready;
    while (n_done < 3 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        check("b2b:sum",  bus.sum,  e[WIDTH-1:0]);
        check("b2b:cout", bus.cout, e[WIDTH+1]);
        check("b2b:ovf",  bus.ovf,  e[WIDTH]);
        done_cyc[n_done] = cyc;
        n_done++;
      end
      if (prev_ready && !bus.ready) begin
        if (issued < 3) begin
          bus.op_sub = 1'($urandom); bus.a = WIDTH'($urandom);
          bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
          exp_q.push_back(model(bus.op_sub, bus.a, bus.b, bus.cin));
          issued++;
        end else begin
          bus.start = 1'b0;
        end
      end
      prev_ready = bus.ready;
    end
    check("b2b:completed", n_done, 3);
    if (n_done == 3) begin
      check("b2b:spacing01", done_cyc[1] - done_cyc[0], WIDTH + 2);
      check("b2b:spacing12", done_cyc[2] - done_cyc[1], WIDTH + 2);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
